// File: rtl/state_timer.sv
// Whole-second countdown timer for the traffic-light sequencer.
// Latches secondsToCount in LOAD and pulses finished at the end of the count.
module state_timer #(
  parameter int unsigned CLK_HZ = 10000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_general,
  input  logic             restart,
  input  logic [CNT_W-1:0] secondsToCount,
  output logic             finished,
  output logic [CNT_W-1:0] remaining,
  output logic             second_tick
);

  localparam int unsigned PW = 16;
  localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             finished_q, finished_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;

  logic wrap;
  logic abort;

  assign wrap  = (presc_q == PMAX);
  // DONE always hands back to LOAD so a held restart keeps pulsing
  assign abort = restart && (state_q == LOAD || state_q == COUNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      finished_q  <= 1'b1;
      remaining_q <= '0;
      presc_q     <= '0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      finished_q  <= finished_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!enable_general) begin
      state_d = IDLE;
    end else if (abort) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = LOAD;
        LOAD:  state_d = (secondsToCount == '0) ? DONE : COUNT;
        COUNT: if (wrap && remaining_q == CNT_W'(1)) state_d = DONE;
        DONE:  state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    finished_d  = 1'b0;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    if (!enable_general) begin
      finished_d  = 1'b1;
      remaining_d = '0;
      presc_d     = '0;
    end else if (abort) begin
      finished_d = 1'b1;
      presc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          remaining_d = secondsToCount;
          presc_d     = '0;
          finished_d  = (secondsToCount == '0);
        end
        COUNT: begin
          if (wrap) begin
            presc_d     = '0;
            tick_d      = 1'b1;
            finished_d  = (remaining_q == CNT_W'(1));
            if (remaining_q != '0) remaining_d = remaining_q - CNT_W'(1);
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        DONE: ;
        default: finished_d = 1'b1;
      endcase
    end
  end

  assign finished    = finished_q;
  assign remaining   = remaining_q;
  assign second_tick = tick_q;

endmodule

// File: tb/tb_state_timer.sv
// Directed bench for state_timer with CLK_HZ=4.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_state_timer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable_general;
  logic             restart;
  logic [CNT_W-1:0] secondsToCount;
  logic             finished;
  logic [CNT_W-1:0] remaining;
  logic             second_tick;

  int checks = 0;
  int errors = 0;

  state_timer #(.CLK_HZ(4), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .enable_general(enable_general),
    .restart(restart),
    .secondsToCount(secondsToCount),
    .finished(finished),
    .remaining(remaining),
    .second_tick(second_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int ticks;
    int t1, t2, t3;
    int fin_low;
    int rem_max;
    logic [15:0] rem_at [0:40];
    logic [5:0] fins;
    logic [3:0] fins4;
    logic found;

    reset = 1'b1;
    enable_general = 1'b0;
    restart = 1'b0;
    secondsToCount = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_fin", 32'(finished), 32'd1);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk("rst_tick", 32'(second_tick), 32'd0);

    // disabled for 10 cycles
    step();
    reset = 1'b1;
    ticks = 0; fin_low = 0; rem_max = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (second_tick) ticks++;
      if (!finished) fin_low++;
      if (int'(remaining) > rem_max) rem_max = int'(remaining);
    end
    chk("dis_fin_low", 32'(fin_low), 32'd0);
    chk("dis_ticks", 32'(ticks), 32'd0);
    chk("dis_rem", 32'(rem_max), 32'd0);

    // 3-second count
    secondsToCount = 16'd3;
    enable_general = 1'b1;
    n = 0; ticks = 0; t1 = 0; t2 = 0; t3 = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n++;
      rem_at[n] = remaining;
      if (n == 3) secondsToCount = 16'd0;
      if (second_tick) begin
        ticks++;
        if (ticks == 1) t1 = n;
        if (ticks == 2) t2 = n;
        if (ticks == 3) t3 = n;
      end
      if (finished) found = 1'b1;
    end
    chk("n3_first_pulse", 32'(n), 32'd14);
    chk("n3_ticks", 32'(ticks), 32'd3);
    chk("n3_tick_gap1", 32'(t2 - t1), 32'd4);
    chk("n3_tick_gap2", 32'(t3 - t2), 32'd4);
    chk("n3_tick_last", 32'(t3), 32'd14);
    chk("n3_rem_a", 32'(rem_at[2]), 32'd3);
    chk("n3_rem_b", 32'(rem_at[6]), 32'd2);
    chk("n3_rem_c", 32'(rem_at[10]), 32'd1);
    chk("n3_rem_d", 32'(rem_at[14]), 32'd0);

    // zero-second states: pulse every 2 cycles
    fins = '0; ticks = 0; rem_max = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      fins = {fins[4:0], finished};
      if (second_tick) ticks++;
      if (int'(remaining) > rem_max) rem_max = int'(remaining);
    end
    chk("n0_pattern", 32'(fins), 32'h15);
    chk("n0_ticks", 32'(ticks), 32'd0);
    chk("n0_rem", 32'(rem_max), 32'd0);

    // disable mid-count at 17
    secondsToCount = 16'd17;
    step();
    step();
    chk("n17_rem", 32'(remaining), 32'd17);
    step();
    enable_general = 1'b0;
    step();
    chk("dis_mid_fin", 32'(finished), 32'd1);
    chk("dis_mid_rem", 32'(remaining), 32'd0);
    step();
    chk("dis_hold_fin", 32'(finished), 32'd1);
    secondsToCount = 16'd1;
    enable_general = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      n++;
      if (finished) found = 1'b1;
    end
    chk("reen_pulse", 32'(n), 32'd6);

    // restart at remaining=2
    secondsToCount = 16'd3;
    step();
    chk("rs_load_fin", 32'(finished), 32'd0);
    step();
    chk("rs_rem3", 32'(remaining), 32'd3);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (remaining == 16'd2) found = 1'b1;
    end
    chk("rs_reach2", 32'(found), 32'd1);
    restart = 1'b1;
    secondsToCount = 16'd2;
    step();
    chk("rs_fin", 32'(finished), 32'd1);
    restart = 1'b0;
    step();
    chk("rs_fin_1cyc", 32'(finished), 32'd0);
    step();
    chk("rs_new_val", 32'(remaining), 32'd2);

    // restart on the same edge as the last tick
    for (int i = 0; i < 4; i++) step();
    chk("lt_rem1", 32'(remaining), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("lt_fin_pre", 32'(finished), 32'd0);
    restart = 1'b1;
    step();
    chk("lt_fin", 32'(finished), 32'd1);
    chk("lt_tick", 32'(second_tick), 32'd0);
    restart = 1'b0;
    secondsToCount = 16'd3;
    fin_low = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (!finished) fin_low++;
    end
    chk("lt_single", 32'(fin_low), 32'd3);

    // held restart from COUNT: DONE, LOAD, DONE, LOAD
    restart = 1'b1;
    fins4 = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      fins4 = {fins4[2:0], finished};
    end
    chk("held_rs", 32'(fins4), 32'hA);

    // async reset mid-count
    restart = 1'b0;
    secondsToCount = 16'd5;
    step();
    chk("ar_rem5", 32'(remaining), 32'd5);
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("ar_fin", 32'(finished), 32'd1);
    chk("ar_rem", 32'(remaining), 32'd0);
    chk("ar_tick", 32'(second_tick), 32'd0);
    #1 reset = 1'b1;
    step();
    chk("ar_load_fin", 32'(finished), 32'd0);
    step();
    chk("ar_resume", 32'(remaining), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
